rgb_led_pwm_ctrl: RTL and testbench
===================================

Name: rgb_led_pwm_ctrl

Overview:
Controller for the board's four RGB LEDs (12 channels), which the FPGA top currently ties low.
- Software (top_arty) writes per-channel 8-bit duty values and an enable mask through a simple write port.
- The block generates glitch-free PWM for all 12 channels from one shared prescaler/period counter.
- Configuration is double-buffered: new settings take effect only at a PWM period boundary.

Parameters:
- NUM_LED, 4: number of RGB LEDs; channels = 3*NUM_LED.
- DUTY_W, 8: duty resolution in bits; PWM period = 2^DUTY_W - 1 ticks.
- PRESCALE, 64: clk cycles per PWM tick; must be >= 1.

Ports:
- clk  in  1  system clock (clk_wiz output).
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  single-cycle write strobe.
- wr_addr  in  4  register index (map below).
- wr_data  in  DUTY_W  write data.
- wr_err  out  1  one-cycle pulse: write to an unmapped address.
- led_r  out  NUM_LED  red channel outputs, bit i = LED i.
- led_g  out  NUM_LED  green channel outputs.
- led_b  out  NUM_LED  blue channel outputs.
- period_start  out  1  one-cycle pulse in the cycle active registers load.

Behaviour:
- Reset (async assert, sync release): all outputs 0; prescaler, pwm_cnt, pending and active duties, and enable masks all 0.
- Address map:
  - addr = 3*i + c (c: 0=R, 1=G, 2=B), for i < NUM_LED: pending duty of that channel.
  - addr = 3*NUM_LED (12): pending enable mask = wr_data[NUM_LED-1:0].
  - All other addresses: no state change; wr_err = 1 in the cycle after wr_en, for 1 cycle.
- Writes update pending registers on the clock edge where wr_en = 1. No back-pressure; a write is accepted every cycle.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick = (presc == PRESCALE-1). With PRESCALE = 1, tick is constant 1.
- pwm_cnt: advances on tick, counting 0..2^DUTY_W-2 (0..254), then wraps to 0.
- Period boundary:
  - Condition: tick && pwm_cnt == 2^DUTY_W-2.
  - On that edge, all pending duties and the pending mask copy to active, and pwm_cnt becomes 0.
  - period_start is registered and is 1 in the cycle after the copy, i.e. the first cycle with pwm_cnt = 0.
- Write coinciding with a boundary copy: the copy takes the pre-write pending value; the new value is stored in pending and applies one period later.
- Output per channel (registered, one cycle after the state it is derived from):
  - led = active_en[i] && (pwm_cnt < active_duty).
  - duty 0 gives constant low; duty 255 gives constant high, with no glitch at wrap.
  - Duty d gives exactly d*PRESCALE high cycles per period of 255*PRESCALE cycles.
- High time is contiguous and starts at pwm_cnt = 0. All channels are phase-aligned.
- Reset mid-period: outputs drop to 0 immediately (asynchronously). After release, counting restarts from 0 with all duties 0.
- The first period after reset always outputs 0. Values written during it become active at the first boundary, 255*PRESCALE cycles after reset release.

Decomposition:
- Package rgb_led_pkg:
  - localparams CH_R = 0, CH_G = 1, CH_B = 2.
  - ADDR_EN = 3*NUM_LED.
  - typedef duty_t (logic [DUTY_W-1:0]).
  - function ch_addr(led, color).
- Sub-module pwm_timebase (prescaler + pwm_cnt + boundary strobe):
  - Outputs tick, pwm_cnt, boundary.
  - Reusable for a future backlight or buzzer PWM.
- The top level holds the register file, shadow copy and comparators.

Test Plan:
1. Reset then idle, PRESCALE = 2 -> all leds 0 for entire first period; period_start first pulses 510 cycles after reset release, then every 510 cycles.
2. Write addr 0 = 128, addr 12 = 4'b0001 during the first period -> after the boundary, led_r[0] is high exactly 256 cycles and low 254 cycles per period; all other leds stay 0.
3. Duty 255 on addr 5 (LED1 B) and duty 0 on addr 4, mask = 4'b0010 -> led_b[1] constant 1 across multiple periods with no low cycle at wrap; led_g[1] constant 0.
4. Write addr 1 = 10 in exactly the boundary cycle while pending = 20 -> next period uses 20 (40 high cycles); the following period uses 10 (20 high cycles).
5. Write addr 13 and addr 15 -> wr_err pulses 1 cycle each, one cycle after the strobe; no register changes and no effect on outputs.
6. Assert reset mid-period with leds active -> all outputs 0 combinationally; after release, outputs stay 0 until reprogrammed and a boundary passes.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared constants, types and address helper for the RGB LED PWM controller
// Purpose: channel colour indices, default geometry, duty type and register address helper.
// Ports: none (package).

package rgb_led_pkg;

  localparam int NUM_LED_DFLT = 4;
  localparam int DUTY_W_DFLT  = 8;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam int ADDR_EN = 3 * NUM_LED_DFLT;

  typedef logic [DUTY_W_DFLT-1:0] duty_t;

  // Register index of a channel; ch_addr(NUM_LED, CH_R) is the enable-mask slot.
  function automatic int ch_addr(input int led, input int color);
    return 3 * led + color;
  endfunction

endpackage

// File: rtl/rgb_led_pwm_ctrl_timebase.sv
// rtl/rgb_led_pwm_ctrl_timebase.sv - shared prescaler and PWM period counter
// Purpose: divides clk by PRESCALE into ticks and counts ticks 0..2^DUTY_W-2.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   o_tick         1 on the last clk cycle of each prescaler interval
//   o_pwm_cnt      current PWM count
//   o_boundary     1 in the cycle whose clock edge ends the PWM period

module pwm_timebase #(
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_tick,
  output logic [DUTY_W-1:0] o_pwm_cnt,
  output logic              o_boundary
);

  localparam int                PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX   = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PW-1:0]     r_presc;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic              w_tick;

  // With PRESCALE = 1 the prescaler is pinned at 0 and the tick is always 1.
  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Period is 2^DUTY_W-1 ticks so a full-scale duty stays high across the wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= (r_pwm_cnt == CNT_MAX) ? '0 : r_pwm_cnt + DUTY_W'(1);
    end
  end

  assign o_tick     = w_tick;
  assign o_pwm_cnt  = r_pwm_cnt;
  assign o_boundary = w_tick && (r_pwm_cnt == CNT_MAX);

endmodule

// File: rtl/rgb_led_pwm_ctrl.sv
// rtl/rgb_led_pwm_ctrl.sv - 12-channel double-buffered PWM controller for the RGB LEDs
// Purpose: pending register file written by software, shadow copy at each period
//          boundary, and per-channel duty comparators driving registered LED outputs.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data single-cycle register write
//   wr_err                one-cycle pulse after a write to an unmapped address
//   led_r/led_g/led_b     PWM outputs, bit i = LED i
//   period_start          one-cycle pulse in the first cycle of a new period

module rgb_led_pwm_ctrl
  import rgb_led_pkg::*;
#(
  parameter int NUM_LED  = NUM_LED_DFLT,
  parameter int DUTY_W   = DUTY_W_DFLT,
  parameter int PRESCALE = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [DUTY_W-1:0]  wr_data,
  output logic               wr_err,
  output logic [NUM_LED-1:0] led_r,
  output logic [NUM_LED-1:0] led_g,
  output logic [NUM_LED-1:0] led_b,
  output logic               period_start
);

  localparam int         NCH     = 3 * NUM_LED;
  localparam logic [3:0] EN_ADDR = 4'(ch_addr(NUM_LED, CH_R));

  logic [DUTY_W-1:0]  r_pend_duty [NCH];
  logic [DUTY_W-1:0]  r_act_duty  [NCH];
  logic [NUM_LED-1:0] r_pend_en;
  logic [NUM_LED-1:0] r_act_en;
  logic [NUM_LED-1:0] r_led_r;
  logic [NUM_LED-1:0] r_led_g;
  logic [NUM_LED-1:0] r_led_b;
  logic               r_wr_err;
  logic               r_period_start;

  logic               w_tick;
  logic [DUTY_W-1:0]  w_pwm_cnt;
  logic               w_boundary;
  logic               w_load;

  pwm_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .i_clk      (clk),
    .i_rst      (reset),
    .o_tick     (w_tick),
    .o_pwm_cnt  (w_pwm_cnt),
    .o_boundary (w_boundary)
  );

  // Boundary already implies a tick; qualifying again keeps the load single-cycle
  // even if a timebase variant reports the wrap count without the tick.
  assign w_load = w_tick && w_boundary;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_pend_duty[ch] <= '0;
      end
      r_pend_en <= '0;
    end else if (wr_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr_addr == 4'(ch)) begin
          r_pend_duty[ch] <= wr_data;
        end
      end
      if (wr_addr == EN_ADDR) begin
        r_pend_en <= wr_data[NUM_LED-1:0];
      end
    end
  end

  // Shadow copy samples pending before any same-edge write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_act_duty[ch] <= '0;
      end
      r_act_en <= '0;
    end else if (w_load) begin
      r_act_duty <= r_pend_duty;
      r_act_en   <= r_pend_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_err       <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_wr_err       <= wr_en && (wr_addr > EN_ADDR);
      r_period_start <= w_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led_r <= '0;
      r_led_g <= '0;
      r_led_b <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        r_led_r[i] <= r_act_en[i] && (w_pwm_cnt < r_act_duty[ch_addr(i, CH_R)]);
        r_led_g[i] <= r_act_en[i] && (w_pwm_cnt < r_act_duty[ch_addr(i, CH_G)]);
        r_led_b[i] <= r_act_en[i] && (w_pwm_cnt < r_act_duty[ch_addr(i, CH_B)]);
      end
    end
  end

  assign led_r        = r_led_r;
  assign led_g        = r_led_g;
  assign led_b        = r_led_b;
  assign wr_err       = r_wr_err;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb/tb_rgb_led_pwm_ctrl.sv - directed self-checking bench for rgb_led_pwm_ctrl (PRESCALE = 2)

module tb_rgb_led_pwm_ctrl;
  import rgb_led_pkg::*;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  duty_t         wr_data = '0;
  logic          wr_err;
  logic [NL-1:0] led_r, led_g, led_b;
  logic          period_start;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   win = 0;
  bit   mon_off = 1'b0;
  int   hcnt [12];
  int   hist [8][12];
  int   ps_cyc [8];
  logic [11:0] w_ch;

  rgb_led_pwm_ctrl #(.NUM_LED(NL), .DUTY_W(8), .PRESCALE(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .led_r        (led_r),
    .led_g        (led_g),
    .led_b        (led_b),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_ch = '0;
    for (int i = 0; i < NL; i++) begin
      w_ch[3*i]   = led_r[i];
      w_ch[3*i+1] = led_g[i];
      w_ch[3*i+2] = led_b[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Per-period high-cycle counters; window k runs from one period_start up to the next.
  always @(negedge clk) begin
    if (!reset && !mon_off) begin
      if (period_start) begin
        if (win < 8) begin
          hist[win]   <= hcnt;
          ps_cyc[win] <= cyc;
        end
        win <= win + 1;
      end
      for (int i = 0; i < 12; i++) begin
        hcnt[i] <= (period_start ? 0 : hcnt[i]) + int'(w_ch[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk($sformatf("reach_%0d", target), cyc, target);
  endtask

  task automatic check_win(input int k, input int r0, input int g0, input int b1);
    int exp;
    for (int ch = 0; ch < 12; ch++) begin
      exp = (ch == 0) ? r0 : (ch == 1) ? g0 : (ch == 5) ? b1 : 0;
      chk($sformatf("win%0d_ch%0d", k, ch), hist[k][ch], exp);
    end
  endtask

  initial begin
    int g;
    int first_ps;
    logic [11:0] led_or;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led_r", led_r, 0);
    chk("rst_led_g", led_g, 0);
    chk("rst_led_b", led_b, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_period_start", period_start, 0);
    reset = 1'b0;

    // First period: program LED0 red at half duty.
    wr(4'd0, 8'd128);
    wr(4'd12, 8'h01);

    // Second period: LED1 blue full, green zero, only LED1 enabled.
    wait_cyc(600);
    wr(4'd5, 8'd255);
    wr(4'd4, 8'd0);
    wr(4'd12, 8'h02);

    // Third period: LED0 green 20, both LEDs enabled.
    wait_cyc(1100);
    wr(4'd1, 8'd20);
    wr(4'd12, 8'h03);

    // Write landing on the boundary edge at cycle 1530.
    wait_cyc(1529);
    wr(4'd1, 8'd10);
    chk("ps_at_1530", period_start, 1);

    // Unmapped addresses.
    wait_cyc(2600);
    wr(4'd13, 8'h00);
    chk("err13", wr_err, 1);
    @(posedge clk); #1;
    chk("err13_clr", wr_err, 0);
    wr(4'd15, 8'h00);
    chk("err15", wr_err, 1);
    @(posedge clk); #1;
    chk("err15_clr", wr_err, 0);
    wr(4'd12, 8'h03);
    chk("err12_none", wr_err, 0);

    g = 0;
    while (win < 6 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("windows_done", (win >= 6), 1);

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ps_cyc%0d", k), ps_cyc[k], 510 * (k + 1));
    end
    check_win(0, 0,   0,  0);
    check_win(1, 256, 0,  0);
    check_win(2, 0,   0,  509);
    check_win(3, 256, 40, 510);
    check_win(4, 256, 20, 510);
    check_win(5, 256, 20, 510);

    // Reset mid-period with LED1 blue driving high.
    wait_cyc(3100);
    mon_off = 1'b1;
    chk("pre_rst_b1", led_b[1], 1);
    reset = 1'b1;
    #1;
    chk("async_led_r", led_r, 0);
    chk("async_led_g", led_g, 0);
    chk("async_led_b", led_b, 0);
    chk("async_ps", period_start, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    led_or   = '0;
    first_ps = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      led_or = led_or | w_ch;
      if (period_start && first_ps == 0) first_ps = n;
    end
    chk("post_rst_leds", led_or, 0);
    chk("post_rst_first_ps", first_ps, 510);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
